// File: rtl/corelet_pkg.sv
// Shared corelet definitions used by the OFIFO drain path.
// Contents:
//   COL, PSUM_BW, ADDR_W  default row geometry and psum SRAM address width
//   drain_state_e         drain job FSM states
package corelet_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned ADDR_W  = 11;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFlush,
        StDone
    } drain_state_e;

endpackage

// File: rtl/drain_hold_reg.sv
// One-entry holding register between the OFIFO pop and the psum SRAM write.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   load         capture din this cycle (takes priority over unload)
//   unload       current entry consumed this cycle
//   din          row to capture
//   valid, dout  entry occupied / entry contents
module drain_hold_reg #(
    parameter int unsigned width = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic [width-1:0] din,
    output logic             valid,
    output logic [width-1:0] dout
);

    logic             valid_q;
    logic [width-1:0] data_q;

    // Load beats unload so a simultaneous accept+pop keeps the entry full
    // with the new row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= din;
        end else if (unload) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/ofifo_drain.sv
// Reader side of the corelet OFIFO: pops psum rows while ofifo_valid is high
// and writes them to consecutive psum SRAM addresses starting at base_addr.
// One-shot job: start, drain exactly num_words rows, pulse done.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   start                   job request, sampled only while idle
//   base_addr, num_words    job parameters, sampled with start (num_words 0 = empty job)
//   ofifo_valid, ofifo_out  OFIFO head row available / head row
//   ofifo_rd                pop OFIFO head this cycle
//   mem_wr_en, mem_addr,
//   mem_wdata, mem_ready    psum SRAM write port (transfer = mem_wr_en & mem_ready)
//   busy                    job in progress
//   done                    one-cycle pulse at job completion
module ofifo_drain
    import corelet_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned addr_w  = ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_addr,
    input  logic [addr_w:0]        num_words,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   mem_wr_en,
    output logic [addr_w-1:0]      mem_addr,
    output logic [col*psum_bw-1:0] mem_wdata,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned RowW = col * psum_bw;

    drain_state_e      state_q;
    logic [addr_w:0]   num_q;
    logic [addr_w:0]   rd_cnt_q;
    logic [addr_w-1:0] addr_q;

    logic              hold_v;
    logic [RowW-1:0]   hold_data;
    logic              accept;
    logic              last_pop;

    assign accept   = mem_wr_en & mem_ready;
    // A pop is allowed when the hold is empty or is being emptied this cycle.
    assign ofifo_rd = (state_q == StDrain) & ofifo_valid & (~hold_v | accept);
    // rd_cnt_q stays below num_q in DRAIN, so the +1 cannot overflow.
    assign last_pop = ofifo_rd & ((rd_cnt_q + {{addr_w{1'b0}}, 1'b1}) == num_q);

    drain_hold_reg #(
        .width (RowW)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (ofifo_rd),
        .unload (accept),
        .din    (ofifo_out),
        .valid  (hold_v),
        .dout   (hold_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            num_q    <= '0;
            rd_cnt_q <= '0;
            addr_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        num_q    <= num_words;
                        addr_q   <= base_addr;
                        rd_cnt_q <= '0;
                        state_q  <= (num_words == '0) ? StDone : StDrain;
                    end
                end
                StDrain: begin
                    if (ofifo_rd) begin
                        rd_cnt_q <= rd_cnt_q + {{addr_w{1'b0}}, 1'b1};
                    end
                    if (accept) begin
                        addr_q <= addr_q + {{(addr_w-1){1'b0}}, 1'b1};
                    end
                    if (last_pop) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (accept) begin
                        addr_q <= addr_q + {{(addr_w-1){1'b0}}, 1'b1};
                    end
                    if (!hold_v || accept) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_wr_en = hold_v;
    assign mem_wdata = hold_data;
    // addr_q wraps naturally, so a full 2^addr_w job covers every address once.
    assign mem_addr  = addr_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule
